// File: rtl/sram_pkg.sv
// Shared types, collision-policy constants and the lane-merge helper for the
// parametrised 1RW+1R SRAM model.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned COLL_READ_FIRST  = 32'd0;
  localparam int unsigned COLL_WRITE_FIRST = 32'd1;

  // Upper bound on DATA_WIDTH handled by lane_merge; callers zero-extend into it.
  localparam int unsigned MERGE_MAX_W = 32'd256;
  localparam int unsigned MERGE_IDX_W = $clog2(MERGE_MAX_W);

  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_W-1:0] mask,
    input int unsigned            byte_width
  );
    logic [MERGE_MAX_W-1:0] merged;
    logic [MERGE_IDX_W-1:0] bit_idx;
    logic [MERGE_IDX_W-1:0] lane_idx;
    merged = old_word;
    for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
      bit_idx  = MERGE_IDX_W'(i);
      lane_idx = MERGE_IDX_W'(i / byte_width);
      if (mask[lane_idx]) begin
        merged[bit_idx] = new_word[bit_idx];
      end else begin
        merged[bit_idx] = old_word[bit_idx];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset initialisation sequencer: walks every address once to zero-fill
// the array, then parks in ST_READY until the next reset.
module sram_init_seq #(
  parameter int unsigned ADDR_WIDTH = 32'd10,
  parameter int unsigned INIT_ZERO  = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic                  init_done
);
  import sram_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  // Next-state and counter logic for the init walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if ((INIT_ZERO == 32'd0) || (cnt_q == LAST_ADDR)) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
    done_d = (state_d == ST_READY);
  end

  // FSM state, address counter and registered done flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= {ADDR_WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // The fill write is suppressed while reset is held so address 0 is written on the first released edge.
  assign init_we   = (state_q == ST_INIT) && (INIT_ZERO != 32'd0) && rst_n;
  assign init_addr = cnt_q;
  assign init_done = done_q;

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised single-clock 1RW+1R SRAM model with byte-lane masking, optional
// output register, selectable collision policy and hardware zero-fill.
module sram_1rw1r_param #(
  parameter  int unsigned DATA_WIDTH = 32'd32,
  parameter  int unsigned ADDR_WIDTH = 32'd10,
  parameter  int unsigned BYTE_WIDTH = 32'd8,
  parameter  int unsigned OUT_REG    = 32'd0,
  parameter  int unsigned COLL_MODE  = 32'd1,
  parameter  int unsigned INIT_ZERO  = 32'd1,
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  rvalid1,
  output logic                  collision,
  output logic                  init_done
);
  import sram_pkg::*;

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_WMASKS-1:0] mask
  );
    return DATA_WIDTH'(lane_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                                  MERGE_MAX_W'(mask), BYTE_WIDTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  init_we_s;
  logic [ADDR_WIDTH-1:0] init_addr_s;
  logic                  init_done_s;
  logic                  accept_s, rd0_s, wr0_s, rd1_s, coll_s;
  logic [DATA_WIDTH-1:0] mem_rd0_s, mem_rd1_s, merged_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  logic [DATA_WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d, coll_q, coll_d;

  sram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_ZERO  (INIT_ZERO)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_we   (init_we_s),
    .init_addr (init_addr_s),
    .init_done (init_done_s)
  );

  // Requests only count once the array is ready and reset is released.
  assign accept_s  = init_done_s && rst_n;
  assign rd0_s     = accept_s && !csb0 && web0;
  assign wr0_s     = accept_s && !csb0 && !web0 && (wmask0 != {NUM_WMASKS{1'b0}});
  assign rd1_s     = accept_s && !csb1;
  assign coll_s    = rd1_s && wr0_s && (addr0 == addr1);
  assign mem_rd0_s = mem_q[addr0];
  assign mem_rd1_s = mem_q[addr1];
  assign merged_s  = merge_word(mem_rd0_s, din0, wmask0);

  // Array write port: the init fill has priority over port 0.
  always_comb begin
    if (init_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = init_addr_s;
      mem_wdata_s = {DATA_WIDTH{1'b0}};
    end else if (wr0_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = addr0;
      mem_wdata_s = merged_s;
    end else begin
      mem_we_s    = 1'b0;
      mem_waddr_s = addr0;
      mem_wdata_s = merged_s;
    end
  end

  // Storage array, written with the already lane-merged word.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // First read stage; port 1 picks merged or pre-write data on a collision.
  always_comb begin
    rvalid0_d = rd0_s;
    rvalid1_d = rd1_s;
    coll_d    = coll_s;
    if (rd0_s) begin
      dout0_d = mem_rd0_s;
    end else begin
      dout0_d = dout0_q;
    end
    if (!rd1_s) begin
      dout1_d = dout1_q;
    end else if (coll_s && (COLL_MODE == COLL_WRITE_FIRST)) begin
      dout1_d = merged_s;
    end else begin
      dout1_d = mem_rd1_s;
    end
  end

  // First read stage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout0_q   <= {DATA_WIDTH{1'b0}};
      dout1_q   <= {DATA_WIDTH{1'b0}};
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      dout0_q   <= dout0_d;
      dout1_q   <= dout1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      coll_q    <= coll_d;
    end
  end

  if (OUT_REG != 32'd0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout0_o_q, dout0_o_d, dout1_o_q, dout1_o_d;
    logic                  rvalid0_o_q, rvalid1_o_q, coll_o_q;

    // Second stage only reloads data when the first stage produced a read.
    always_comb begin
      if (rvalid0_q) begin
        dout0_o_d = dout0_q;
      end else begin
        dout0_o_d = dout0_o_q;
      end
      if (rvalid1_q) begin
        dout1_o_d = dout1_q;
      end else begin
        dout1_o_d = dout1_o_q;
      end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout0_o_q   <= {DATA_WIDTH{1'b0}};
        dout1_o_q   <= {DATA_WIDTH{1'b0}};
        rvalid0_o_q <= 1'b0;
        rvalid1_o_q <= 1'b0;
        coll_o_q    <= 1'b0;
      end else begin
        dout0_o_q   <= dout0_o_d;
        dout1_o_q   <= dout1_o_d;
        rvalid0_o_q <= rvalid0_q;
        rvalid1_o_q <= rvalid1_q;
        coll_o_q    <= coll_q;
      end
    end

    assign dout0     = dout0_o_q;
    assign dout1     = dout1_o_q;
    assign rvalid0   = rvalid0_o_q;
    assign rvalid1   = rvalid1_o_q;
    assign collision = coll_o_q;
  end else begin : g_no_out_reg
    assign dout0     = dout0_q;
    assign dout1     = dout1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign collision = coll_q;
  end

  assign init_done = init_done_s;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench: a write-first/latency-1 and a read-first/latency-2 instance
// share stimulus; a third instance covers the no-fill init path.
module tb_sram_1rw1r_param;

  typedef struct {
    logic [31:0] data;
    logic        coll;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n, csb0, web0, csb1;
  logic [3:0]  wmask0, addr0, addr1;
  logic [31:0] din0;

  logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1, c_dout0, c_dout1;
  logic        a_rvalid0, a_rvalid1, a_collision, a_init_done;
  logic        b_rvalid0, b_rvalid1, b_collision, b_init_done;
  logic        c_rvalid0, c_rvalid1, c_collision, c_init_done;

  int          cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [16];
  exp_t        q0[$], q1[$], q2[$], q3[$];

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                     .OUT_REG(0), .COLL_MODE(1), .INIT_ZERO(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(a_dout0), .rvalid0(a_rvalid0),
    .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .rvalid1(a_rvalid1),
    .collision(a_collision), .init_done(a_init_done));

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                     .OUT_REG(1), .COLL_MODE(0), .INIT_ZERO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(b_dout0), .rvalid0(b_rvalid0),
    .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .rvalid1(b_rvalid1),
    .collision(b_collision), .init_done(b_init_done));

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                     .OUT_REG(0), .COLL_MODE(1), .INIT_ZERO(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .csb0(1'b1), .web0(1'b1), .wmask0(4'h0),
    .addr0(4'h0), .din0(32'h0), .dout0(c_dout0), .rvalid0(c_rvalid0),
    .csb1(1'b1), .addr1(4'h0), .dout1(c_dout1), .rvalid1(c_rvalid1),
    .collision(c_collision), .init_done(c_init_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int l = 0; l < 4; l++) if (m[l]) r[l*8 +: 8] = n[l*8 +: 8];
    return r;
  endfunction

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      default: return 0;
    endcase
  endfunction

  function automatic int qfront_cyc(input int p);
    case (p)
      0: return q0[0].cyc;
      1: return q1[0].cyc;
      2: return q2[0].cyc;
      3: return q3[0].cyc;
      default: return 0;
    endcase
  endfunction

  task automatic qpush(input int p, input exp_t e);
    case (p)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: ;
    endcase
  endtask

  task automatic qpop(input int p, output exp_t e);
    case (p)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      2: e = q2.pop_front();
      3: e = q3.pop_front();
      default: e = '{32'h0, 1'b0, 0};
    endcase
  endtask

  // Ports 0/2 are port 0 of dut_a/dut_b, ports 1/3 their port 1.
  task automatic mon(input int p, input logic rv, input logic [31:0] d, input logic cl);
    exp_t e;
    while (qsize(p) > 0 && qfront_cyc(p) < cyc) begin
      qpop(p, e);
      chk($sformatf("p%0d_missing_rvalid_cycle", p), 32'(cyc), 32'(e.cyc));
    end
    if (rv) begin
      if (qsize(p) == 0) begin
        chk1($sformatf("p%0d_spurious_rvalid", p), rv, 1'b0);
      end else begin
        qpop(p, e);
        chk($sformatf("p%0d_data", p), d, e.data);
        chk($sformatf("p%0d_cycle", p), 32'(cyc), 32'(e.cyc));
        if (p % 2 == 1) chk1($sformatf("p%0d_collision", p), cl, e.coll);
      end
    end else if (p % 2 == 1) begin
      chk1($sformatf("p%0d_collision_idle", p), cl, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_rvalid0, a_dout0, 1'b0);
    mon(1, a_rvalid1, a_dout1, a_collision);
    mon(2, b_rvalid0, b_dout0, 1'b0);
    mon(3, b_rvalid1, b_dout1, b_collision);
    chk1("c_no_rvalid", c_rvalid0 | c_rvalid1 | c_collision, 1'b0);
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_a_dout0"}, a_dout0, 32'h0);
    chk({tag, "_a_dout1"}, a_dout1, 32'h0);
    chk1({tag, "_a_rvalid0"}, a_rvalid0, 1'b0);
    chk1({tag, "_a_rvalid1"}, a_rvalid1, 1'b0);
    chk1({tag, "_a_collision"}, a_collision, 1'b0);
    chk1({tag, "_a_init_done"}, a_init_done, 1'b0);
    chk({tag, "_b_dout0"}, b_dout0, 32'h0);
    chk({tag, "_b_dout1"}, b_dout1, 32'h0);
    chk1({tag, "_b_rvalid0"}, b_rvalid0, 1'b0);
    chk1({tag, "_b_rvalid1"}, b_rvalid1, 1'b0);
    chk1({tag, "_b_init_done"}, b_init_done, 1'b0);
    chk1({tag, "_c_init_done"}, c_init_done, 1'b0);
    chk({tag, "_c_dout"}, c_dout0 | c_dout1, 32'h0);
  endtask

  // Drive one cycle of requests, push expected read results, then pass the edge.
  task automatic step(input logic c0, input logic w0, input logic [3:0] m0,
                      input logic [3:0] a0, input logic [31:0] d0,
                      input logic c1, input logic [3:0] a1, input bit push_b);
    int          n;
    logic [31:0] old1;
    logic        cl;
    exp_t        e;
    csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
    n = cyc + 1;
    if (!c0 && w0) begin
      e = '{model[a0], 1'b0, n};
      qpush(0, e);
      if (push_b) begin e.cyc = n + 1; qpush(2, e); end
    end
    if (!c1) begin
      old1 = model[a1];
      cl   = !c0 && !w0 && (m0 != 4'h0) && (a0 == a1);
      e    = '{(cl ? tb_merge(old1, d0, m0) : old1), cl, n};
      qpush(1, e);
      if (push_b) begin e.data = old1; e.cyc = n + 1; qpush(3, e); end
    end
    if (!c0 && !w0) model[a0] = tb_merge(model[a0], d0, m0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1);
  endtask

  task automatic wait_init(input string tag);
    int n;
    for (n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        chk1({tag, "_c_done_first_edge"}, c_init_done, 1'b1);
        chk1({tag, "_a_not_done_yet"}, a_init_done, 1'b0);
      end
      if (a_init_done) break;
    end
    chk({tag, "_edges_to_done"}, 32'(n), 32'd16);
    chk1({tag, "_b_done"}, b_init_done, 1'b1);
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; csb1 = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0;
    addr0 = 4'h0; din0 = 32'h0; csb1 = 1'b1; addr1 = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");

    // Release reset with a write and reads pending; all of them must be ignored.
    @(posedge clk); #1;
    rst_n = 1'b1; csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF;
    addr0 = 4'd3; din0 = 32'hDEAD_BEEF; csb1 = 1'b0; addr1 = 4'd3;
    wait_init("init1");

    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'(15 - i), 1'b1);

    step(1'b0, 1'b0, 4'hF, 4'd5, 32'h1122_3344, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b0, 4'b0101, 4'd5, 32'hAABB_CCDD, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'd5, 1'b1);
    idle(2);

    step(1'b0, 1'b0, 4'hF, 4'd7, 32'hFFFF_FFFF, 1'b0, 4'd7, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 4'h0, 4'd7, 32'h1234_5678, 1'b0, 4'd7, 1'b1);
    step(1'b0, 1'b0, 4'b0011, 4'd7, 32'h0, 1'b0, 4'd6, 1'b1);
    step(1'b0, 1'b0, 4'b1000, 4'd7, 32'hA500_0000, 1'b0, 4'd7, 1'b1);
    idle(2);

    step(1'b0, 1'b0, 4'hF, 4'd1, 32'h0101_0101, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b0, 4'hF, 4'd2, 32'h0202_0202, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'd1, 32'h0, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'd0, 1'b1);
    idle(3);

    // Reset lands while dut_b still has the last read in flight.
    step(1'b0, 1'b0, 4'hF, 4'd0, 32'hCAFE_0000, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b0, 4'hF, 4'd15, 32'hCAFE_000F, 1'b1, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'd1, 32'h0, 1'b0, 4'd2, 1'b0);
    rst_n = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; csb1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("init2");

    step(1'b0, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd15, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'd15, 32'h0, 1'b0, 4'd0, 1'b1);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
